// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, widths, port indices
// and the request payload carried onto the ALU operand bus.
package alu_arb_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned N_PORT = 2;

  localparam int unsigned P0 = 0;
  localparam int unsigned P1 = 1;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_IDLE   = 4'b1111
  } alu_op_e;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } alu_req_t;

  // Bus value presented to the ALU when nothing is granted.
  function automatic alu_req_t idle_req();
    alu_req_t r;
    r.opcode = OP_IDLE;
    r.a      = '0;
    r.b      = '0;
    return r;
  endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry response holding register. A fill always wins over a drain, so a
// port can hand off and refill in the same cycle without dropping rsp_valid.
module alu_rsp_slot
  import alu_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_i,
  input  logic [WIDTH-1:0] fill_data_i,
  input  logic             rsp_ready_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             can_accept_c_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      data_d  = fill_data_i;
    end else if (valid_q && rsp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid_o    = valid_q;
  assign rsp_data_o     = data_q;
  assign can_accept_c_o = !valid_q || rsp_ready_i;

endmodule

// File: rtl/alu_port_arbiter.sv
// Shares one single-cycle ALU between the execute stage (port 0) and an
// auxiliary requester (port 1) with bounded starvation for port 1.
module alu_port_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned P1_MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             p0_req_valid,
  output logic             p0_req_ready,
  input  logic [OP_W-1:0]  p0_opcode,
  input  logic [WIDTH-1:0] p0_a,
  input  logic [WIDTH-1:0] p0_b,
  output logic             p0_rsp_valid,
  input  logic             p0_rsp_ready,
  output logic [WIDTH-1:0] p0_rsp_data,

  input  logic             p1_req_valid,
  output logic             p1_req_ready,
  input  logic [OP_W-1:0]  p1_opcode,
  input  logic [WIDTH-1:0] p1_a,
  input  logic [WIDTH-1:0] p1_b,
  output logic             p1_rsp_valid,
  input  logic             p1_rsp_ready,
  output logic [WIDTH-1:0] p1_rsp_data,

  output logic [OP_W-1:0]  alu_opcode,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_result,
  output logic             alu_flag_en
);

  localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(P1_MAX_WAIT);

  logic [N_PORT-1:0] can_accept;
  logic [N_PORT-1:0] elig;
  logic [N_PORT-1:0] grant;
  logic              force_p1;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  alu_req_t          req0, req1, alu_req;

  assign req0 = '{opcode: p0_opcode, a: p0_a, b: p0_b};
  assign req1 = '{opcode: p1_opcode, a: p1_a, b: p1_b};

  // Nothing is eligible while reset is held, so ready stays low asynchronously.
  always_comb begin
    elig       = '0;
    grant      = '0;
    elig[P0]   = rst && p0_req_valid && can_accept[P0];
    elig[P1]   = rst && p1_req_valid && can_accept[P1];
    force_p1   = (wait_cnt_q == MAX_WAIT);
    grant[P1]  = elig[P1] && (!elig[P0] || force_p1);
    grant[P0]  = elig[P0] && !grant[P1];
  end

  // Counts consecutive conflict cycles that port 1 has lost.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!elig[P1] || grant[P1]) begin
      wait_cnt_d = '0;
    end else if (grant[P0] && (wait_cnt_q != MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // The ALU is combinational, so its bus follows the grant in the same cycle.
  always_comb begin
    alu_req = idle_req();
    if (grant[P0]) begin
      alu_req = req0;
    end else if (grant[P1]) begin
      alu_req = req1;
    end
  end

  assign alu_opcode   = alu_req.opcode;
  assign alu_in1      = alu_req.a;
  assign alu_in2      = alu_req.b;
  assign alu_flag_en  = grant[P0];
  assign p0_req_ready = grant[P0];
  assign p1_req_ready = grant[P1];

  alu_rsp_slot u_slot0 (
    .clk            (clk),
    .rst            (rst),
    .fill_i         (grant[P0]),
    .fill_data_i    (alu_result),
    .rsp_ready_i    (p0_rsp_ready),
    .rsp_valid_o    (p0_rsp_valid),
    .rsp_data_o     (p0_rsp_data),
    .can_accept_c_o (can_accept[P0])
  );

  alu_rsp_slot u_slot1 (
    .clk            (clk),
    .rst            (rst),
    .fill_i         (grant[P1]),
    .fill_data_i    (alu_result),
    .rsp_ready_i    (p1_rsp_ready),
    .rsp_valid_o    (p1_rsp_valid),
    .rsp_data_o     (p1_rsp_data),
    .can_accept_c_o (can_accept[P1])
  );

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Bench for alu_port_arbiter: directed scenarios plus a randomized run against
// a transaction-level model of arbitration and response slots.
module tb_alu_port_arbiter;
  import alu_arb_pkg::*;

  localparam int unsigned MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_ready;
  logic [3:0]  p0_opcode;
  logic [15:0] p0_a, p0_b, p0_rsp_data;
  logic        p1_req_valid, p1_req_ready, p1_rsp_valid, p1_rsp_ready;
  logic [3:0]  p1_opcode;
  logic [15:0] p1_a, p1_b, p1_rsp_data;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_in1, alu_in2, alu_result;
  logic        alu_flag_en;

  int errors = 0;
  int checks = 0;

  alu_port_arbiter #(.P1_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_opcode(p0_opcode),
    .p0_a(p0_a), .p0_b(p0_b), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
    .p0_rsp_data(p0_rsp_data),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_opcode(p1_opcode),
    .p1_a(p1_a), .p1_b(p1_b), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
    .p1_rsp_data(p1_rsp_data),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .alu_flag_en(alu_flag_en)
  );

  always #5 clk = ~clk;

  // Behavioural ALU sitting on the arbiter's operand bus.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    s = '0;
    r = 16'h0000;
    case (op)
      OP_ADD: begin
        s = {a[15], a} + {b[15], b};
        r = (s[16] != s[15]) ? (s[16] ? 16'h8000 : 16'h7FFF) : s[15:0];
      end
      OP_SUB: begin
        s = {a[15], a} - {b[15], b};
        r = (s[16] != s[15]) ? (s[16] ? 16'h8000 : 16'h7FFF) : s[15:0];
      end
      OP_XOR:    r = a ^ b;
      OP_RED:    r = 16'(a[15:8]) + 16'(a[7:0]);
      OP_SLL:    r = a << b[3:0];
      OP_SRA:    r = 16'($signed(a) >>> b[3:0]);
      OP_ROR:    r = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));
      OP_PADDSB: r = {a[15:8] + b[15:8], a[7:0] + b[7:0]};
      default:   r = 16'h0000;
    endcase
    return r;
  endfunction

  always_comb alu_result = alu_fn(alu_opcode, alu_in1, alu_in2);

  task automatic drive(input logic v0, input logic [3:0] o0, input logic [15:0] a0,
                       input logic [15:0] b0, input logic r0,
                       input logic v1, input logic [3:0] o1, input logic [15:0] a1,
                       input logic [15:0] b1, input logic r1);
    p0_req_valid = v0; p0_opcode = o0; p0_a = a0; p0_b = b0; p0_rsp_ready = r0;
    p1_req_valid = v1; p1_opcode = o1; p1_a = a1; p1_b = b1; p1_rsp_ready = r1;
  endtask

  task automatic settle();
    repeat (2) begin
      @(negedge clk);
      drive(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, OP_ADD, 16'h1111, 16'h2222, 1'b1, 1'b1, OP_SUB, 16'h3, 16'h4, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({p0_req_ready, p1_req_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_req_ready: got %b want 00", {p0_req_ready, p1_req_ready});
    end
    checks++;
    if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00 || p0_rsp_data !== 16'h0 || p1_rsp_data !== 16'h0) begin
      errors++; $display("FAIL reset_rsp: got v=%b d0=%h d1=%h want 00/0000/0000",
                         {p0_rsp_valid, p1_rsp_valid}, p0_rsp_data, p1_rsp_data);
    end
    checks++;
    if (alu_opcode !== 4'hF || alu_in1 !== 16'h0 || alu_in2 !== 16'h0 || alu_flag_en !== 1'b0) begin
      errors++; $display("FAIL reset_alu_bus: got op=%h in1=%h in2=%h fe=%b want f/0000/0000/0",
                         alu_opcode, alu_in1, alu_in2, alu_flag_en);
    end
    @(negedge clk);
    drive(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1);
    rst = 1'b1;
  endtask

  task automatic test_single_p0();
    @(negedge clk);
    drive(1'b1, OP_ADD, 16'h0003, 16'h0004, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1);
    #1;
    checks++;
    if (p0_req_ready !== 1'b1 || alu_flag_en !== 1'b1) begin
      errors++; $display("FAIL p0_grant: got rdy=%b fe=%b want 1/1", p0_req_ready, alu_flag_en);
    end
    checks++;
    if (alu_opcode !== OP_ADD || alu_in1 !== 16'h0003 || alu_in2 !== 16'h0004) begin
      errors++; $display("FAIL p0_bus: got op=%h in1=%h in2=%h want 0/0003/0004", alu_opcode, alu_in1, alu_in2);
    end
    @(posedge clk); #1;
    checks++;
    if (p0_rsp_valid !== 1'b1 || p0_rsp_data !== 16'h0007) begin
      errors++; $display("FAIL p0_rsp: got v=%b d=%h want 1/0007", p0_rsp_valid, p0_rsp_data);
    end
    @(negedge clk);
    p0_req_valid = 1'b0;
    #1;
    checks++;
    if (alu_opcode !== 4'hF || alu_flag_en !== 1'b0) begin
      errors++; $display("FAIL idle_bus: got op=%h fe=%b want f/0", alu_opcode, alu_flag_en);
    end
    @(posedge clk); #1;
    checks++;
    if (p0_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL p0_drain: got v=%b want 0", p0_rsp_valid);
    end
  endtask

  task automatic test_p1_only();
    @(negedge clk);
    drive(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b1, OP_SUB, 16'h0005, 16'h0005, 1'b1);
    #1;
    checks++;
    if (p1_req_ready !== 1'b1 || alu_flag_en !== 1'b0 || alu_opcode !== OP_SUB) begin
      errors++; $display("FAIL p1_grant: got rdy=%b fe=%b op=%h want 1/0/1", p1_req_ready, alu_flag_en, alu_opcode);
    end
    @(posedge clk); #1;
    checks++;
    if (p1_rsp_valid !== 1'b1 || p1_rsp_data !== 16'h0000 || alu_flag_en !== 1'b0) begin
      errors++; $display("FAIL p1_rsp: got v=%b d=%h fe=%b want 1/0000/0", p1_rsp_valid, p1_rsp_data, alu_flag_en);
    end
    settle();
  endtask

  task automatic test_starvation();
    logic [15:0] a1, b1, exp1;
    bit          g1;
    a1 = 16'($urandom); b1 = 16'($urandom);
    for (int i = 0; i < 3 * (MAXW + 1); i++) begin
      @(negedge clk);
      drive(1'b1, OP_XOR, 16'($urandom), 16'($urandom), 1'b1, 1'b1, OP_PADDSB, a1, b1, 1'b1);
      g1 = ((i % (MAXW + 1)) == MAXW);
      #1;
      checks++;
      if (p1_req_ready !== g1 || p0_req_ready !== !g1) begin
        errors++; $display("FAIL starve_grant[%0d]: got r0=%b r1=%b want r0=%b r1=%b",
                           i, p0_req_ready, p1_req_ready, !g1, g1);
      end
      exp1 = alu_fn(OP_PADDSB, a1, b1);
      @(posedge clk); #1;
      checks++;
      if (p1_rsp_valid !== g1 || (g1 && p1_rsp_data !== exp1)) begin
        errors++; $display("FAIL starve_p1_rsp[%0d]: got v=%b d=%h want v=%b d=%h",
                           i, p1_rsp_valid, p1_rsp_data, g1, exp1);
      end
      if (g1) begin
        a1 = 16'($urandom); b1 = 16'($urandom);
      end
    end
    settle();
  endtask

  task automatic test_backpressure();
    logic [15:0] first;
    first = 16'hA5A5 ^ 16'h0F0F;
    @(negedge clk);
    drive(1'b1, OP_XOR, 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, OP_ADD, 16'h1234, 16'h1111, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1);
      #1;
      checks++;
      if (p0_req_ready !== 1'b0 || p0_rsp_valid !== 1'b1 || p0_rsp_data !== first) begin
        errors++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h want 0/1/%h",
                           i, p0_req_ready, p0_rsp_valid, p0_rsp_data, first);
      end
    end
    @(negedge clk);
    p0_rsp_ready = 1'b1;
    #1;
    checks++;
    if (p0_req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept: got rdy=%b want 1", p0_req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (p0_rsp_valid !== 1'b1 || p0_rsp_data !== 16'h2345) begin
      errors++; $display("FAIL bp_handoff: got v=%b d=%h want 1/2345", p0_rsp_valid, p0_rsp_data);
    end
    settle();
  endtask

  task automatic test_saturation();
    @(negedge clk);
    drive(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (p0_rsp_valid !== 1'b1 || p0_rsp_data !== 16'h7FFF) begin
      errors++; $display("FAIL saturate: got v=%b d=%h want 1/7fff", p0_rsp_valid, p0_rsp_data);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b1, OP_XOR, 16'h00FF, 16'h0F00, 1'b0, 1'b1, OP_SLL, 16'h0001, 16'h0004, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({p0_rsp_valid, p1_rsp_valid} !== 2'b11) begin
      errors++; $display("FAIL mid_fill: got v=%b want 11", {p0_rsp_valid, p1_rsp_valid});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00 || alu_opcode !== 4'hF ||
        {p0_req_ready, p1_req_ready} !== 2'b00) begin
      errors++; $display("FAIL mid_reset: got v=%b op=%h rdy=%b want 00/f/00",
                         {p0_rsp_valid, p1_rsp_valid}, alu_opcode, {p0_req_ready, p1_req_ready});
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, OP_ADD, 16'h0001, 16'h0002, 1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1);
    #1;
    checks++;
    if (p0_req_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready: got %b want 1", p0_req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (p0_rsp_valid !== 1'b1 || p0_rsp_data !== 16'h0003) begin
      errors++; $display("FAIL post_reset_rsp: got v=%b d=%h want 1/0003", p0_rsp_valid, p0_rsp_data);
    end
    settle();
  endtask

  task automatic test_random();
    bit          v0, v1, r0, r1, pend0, pend1, full0, full1, e0, e1, g0, g1;
    logic [3:0]  o0, o1, exp_op;
    logic [15:0] a0, b0, a1, b1, d0, d1;
    int          losses;
    pend0 = 0; pend1 = 0; full0 = 0; full1 = 0; losses = 0;
    v0 = 0; v1 = 0; o0 = '0; o1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; d0 = '0; d1 = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!pend0) begin
        v0 = ($urandom_range(0, 3) != 0);
        o0 = 4'($urandom_range(0, 7)); a0 = 16'($urandom); b0 = 16'($urandom);
        pend0 = v0;
      end
      if (!pend1) begin
        v1 = ($urandom_range(0, 2) != 0);
        o1 = 4'($urandom_range(0, 7)); a1 = 16'($urandom); b1 = 16'($urandom);
        pend1 = v1;
      end
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 2) != 0);
      drive(v0, o0, a0, b0, r0, v1, o1, a1, b1, r1);
      e0 = v0 && (!full0 || r0);
      e1 = v1 && (!full1 || r1);
      g1 = e1 && (!e0 || losses == MAXW);
      g0 = e0 && !g1;
      exp_op = g0 ? o0 : (g1 ? o1 : 4'hF);
      #1;
      checks++;
      if (p0_req_ready !== g0 || p1_req_ready !== g1 || alu_flag_en !== g0) begin
        errors++; $display("FAIL rand_grant[%0d]: got r0=%b r1=%b fe=%b want %b/%b/%b",
                           cyc, p0_req_ready, p1_req_ready, alu_flag_en, g0, g1, g0);
      end
      checks++;
      if (alu_opcode !== exp_op || alu_in1 !== (g0 ? a0 : (g1 ? a1 : 16'h0))) begin
        errors++; $display("FAIL rand_bus[%0d]: got op=%h in1=%h want op=%h", cyc, alu_opcode, alu_in1, exp_op);
      end
      @(posedge clk); #1;
      losses = (e1 && !g1) ? losses + 1 : 0;
      if (g0) begin full0 = 1; d0 = alu_fn(o0, a0, b0); pend0 = 0; end
      else if (full0 && r0) full0 = 0;
      if (g1) begin full1 = 1; d1 = alu_fn(o1, a1, b1); pend1 = 0; end
      else if (full1 && r1) full1 = 0;
      checks++;
      if (p0_rsp_valid !== full0 || (full0 && p0_rsp_data !== d0)) begin
        errors++; $display("FAIL rand_p0_rsp[%0d]: got v=%b d=%h want v=%b d=%h",
                           cyc, p0_rsp_valid, p0_rsp_data, full0, d0);
      end
      checks++;
      if (p1_rsp_valid !== full1 || (full1 && p1_rsp_data !== d1)) begin
        errors++; $display("FAIL rand_p1_rsp[%0d]: got v=%b d=%h want v=%b d=%h",
                           cyc, p1_rsp_valid, p1_rsp_data, full1, d1);
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_single_p0();
    test_p1_only();
    test_starvation();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_port_arbiter.md
# alu_port_arbiter

Shares the single-cycle 16-bit ALU between two requesters. Port 0 is the pipeline execute stage; port 1 is an auxiliary requester such as the address-generation or debug unit. The block arbitrates with a bounded-starvation priority scheme, drives the ALU operand and opcode bus, and captures each result into a one-entry per-port response slot with a valid/ready handshake. It also gates the ALU flag-register write so that only port-0 operations can change Z/V/N.

## Interface
- P1_MAX_WAIT, default 4: number of consecutive conflict cycles port 1 may lose before it is forced to win once. Legal range 0..15; 0 means port 1 always wins conflicts.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- p0_req_valid  in  1  port-0 request present.
- p0_req_ready  out  1  port-0 request accepted this cycle.
- p0_opcode  in  4  ALU opcode for port 0.
- p0_a  in  16  first operand for port 0.
- p0_b  in  16  second operand for port 0.
- p0_rsp_valid  out  1  port-0 result held.
- p0_rsp_ready  in  1  port-0 consumer takes the result.
- p0_rsp_data  out  16  port-0 result.
- p1_req_valid, p1_req_ready, p1_opcode, p1_a, p1_b, p1_rsp_valid, p1_rsp_ready, p1_rsp_data: same widths and meanings, for port 1.
- alu_opcode  out  4  to the ALU Opcode input.
- alu_in1  out  16  to the ALU Input1.
- alu_in2  out  16  to the ALU Input2.
- alu_result  in  16  ALU Output (combinational).
- alu_flag_en  out  1  ANDed into the ALU's flag-register set term.

## Operation
- Eligibility: port N is eligible when pN_req_valid=1 and its slot can accept. A slot can accept when it is empty, or when pN_rsp_ready=1 in the same cycle.
- Grant, decided combinationally each cycle:
  - Only one port eligible: grant that port.
  - Both ports eligible: grant port 0, unless wait_cnt==P1_MAX_WAIT, in which case grant port 1.
  - Neither eligible: no grant.
- pN_req_ready = grantN. Ready may depend on both valids. A requester must not make valid depend on ready, and must hold its request fields stable while valid=1 and ready=0.
- wait_cnt (4-bit register):
  - Cleared when port 1 is granted or is not eligible.
  - Incremented, saturating at P1_MAX_WAIT, when port 1 is eligible but port 0 is granted.
- ALU drive:
  - On a grant: alu_opcode, alu_in1 and alu_in2 carry the granted port's fields.
  - With no grant: alu_opcode=4'b1111, and alu_in1=alu_in2=16'h0000.
- alu_flag_en = grant0. It is 0 for port-1 grants and for idle cycles, so port-1 ADD/SUB/XOR/shift operations never alter the flags.
- Response slot:
  - On a grant, alu_result is registered into the granted port's slot and that port's rsp_valid is set.
  - A slot is cleared when rsp_valid=1 and rsp_ready=1 and no new fill arrives in the same cycle.
  - Drain and fill in the same cycle: rsp_valid stays 1 and rsp_data takes the new result.
- The arbiter does not interpret opcodes. Saturation and sign behaviour are the ALU's.

## Timing
- Latency: a request accepted in cycle N returns rsp_valid=1 with its data in cycle N+1.
- Throughput: one operation per cycle in total across both ports. Each port sustains one per cycle if its consumer holds rsp_ready=1.
- Reset values: all pN_req_ready=0 while rst=0, all pN_rsp_valid=0, all pN_rsp_data=16'h0000, wait_cnt=0, alu_opcode=4'b1111, alu_in1=alu_in2=0, alu_flag_en=0.
- Reset asserted mid-operation: slot contents are discarded immediately, with no response delivered. The first grant is possible in the first rising edge after rst deasserts.
- rsp_data is stable while rsp_valid=1 and rsp_ready=0.
- Worst-case port-1 wait under continuous conflict: P1_MAX_WAIT cycles. The forced win occurs in cycle P1_MAX_WAIT+1.

## Structure
- Shared package alu_arb_pkg:
  - Opcode constants OP_ADD=4'b0000, OP_SUB=4'b0001, OP_XOR=4'b0010, OP_RED=4'b0011, OP_SLL=4'b0100, OP_SRA=4'b0101, OP_ROR=4'b0110, OP_PADDSB=4'b0111, OP_IDLE=4'b1111.
  - Constant WIDTH=16.
  - Port-index constants P0=0, P1=1.
- Sub-module alu_rsp_slot: one-entry response register with fill/drain logic, instantiated once per port.
- Grant logic and wait_cnt live in the top module.

## Test plan
- Single port-0 request ADD 16'h0003 + 16'h0004 with rsp_ready=1 -> p0_req_ready=1 and alu_flag_en=1 in the same cycle; next cycle p0_rsp_valid=1 and p0_rsp_data=16'h0007.
- Port-1 SUB 16'h0005 − 16'h0005 alone -> p1_rsp_data=16'h0000, and alu_flag_en stays 0 throughout, so the flags register keeps its prior value.
- Both ports valid continuously with P1_MAX_WAIT=4 and both rsp_ready=1 -> grant pattern is P0,P0,P0,P0,P1, repeating; port-1 results arrive every 5th cycle.
- p0_rsp_ready=0 with a result held and a new p0 request valid -> p0_req_ready=0 and p0_rsp_data held. When rsp_ready rises, the request is accepted in that same cycle and rsp_valid stays 1 across the handoff.
- Port-0 ADD 16'h7FFF + 16'h0001 -> p0_rsp_data=16'h7FFF (ALU saturation passes through unchanged).
- rst driven low while both slots are full -> both rsp_valid drop to 0 asynchronously and alu_opcode=4'b1111. After release, the first request completes with normal N+1 latency.
